// File: rtl/idexe_stage_reg_pkg.sv
// Shared ID/EXE pipeline definitions: default widths, ALU op codes, stage bundle.
package idexe_stage_reg_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int ALUC_W_DEF = 4;

  // ALU control codes driven by the decode control unit
  localparam logic [ALUC_W_DEF-1:0] ALU_ADD = 4'h0;
  localparam logic [ALUC_W_DEF-1:0] ALU_AND = 4'h1;
  localparam logic [ALUC_W_DEF-1:0] ALU_XOR = 4'h2;
  localparam logic [ALUC_W_DEF-1:0] ALU_SLL = 4'h3;
  localparam logic [ALUC_W_DEF-1:0] ALU_SUB = 4'h4;
  localparam logic [ALUC_W_DEF-1:0] ALU_OR  = 4'h5;
  localparam logic [ALUC_W_DEF-1:0] ALU_LUI = 4'h6;
  localparam logic [ALUC_W_DEF-1:0] ALU_SRL = 4'h7;
  localparam logic [ALUC_W_DEF-1:0] ALU_SRA = 4'hf;

  // ID/EXE bundle at default widths; control bits sit in the MSBs
  typedef struct packed {
    logic                  wreg;
    logic                  m2reg;
    logic                  wmem;
    logic                  aluimm;
    logic [ALUC_W_DEF-1:0] aluc;
    logic [REG_AW_DEF-1:0] dest_reg;
    logic [DATA_W_DEF-1:0] qa;
    logic [DATA_W_DEF-1:0] qb;
    logic [DATA_W_DEF-1:0] imm32;
  } idexe_bundle_t;

  // Packed width of a bundle for arbitrary field widths
  function automatic int bundle_w(int data_w, int reg_aw, int aluc_w);
    return 4 + aluc_w + reg_aw + 3 * data_w;
  endfunction

endpackage

// File: rtl/idexe_stage_reg_skid_buf.sv
// Generic one-entry valid/ready stage on a packed vector, optional skid entry.
// Flush drops everything held plus the same-cycle input; data registers hold.
module pipe_skid_buf #(
  parameter int W    = 8,
  parameter int SKID = 1
)(
  input  logic         clk,
  input  logic         clrn,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic in_acc, slot_free;

  assign in_acc    = in_valid && in_ready;
  assign slot_free = !out_valid || out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic         skid_valid;
      logic [W-1:0] skid_data;

      // ready comes straight from a flop so stalls never form a comb path upstream
      assign in_ready = !skid_valid;

      // output slot refills from skid first, so order is kept
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          out_valid  <= 1'b0;
          out_data   <= '0;
          skid_valid <= 1'b0;
          skid_data  <= '0;
        end else if (flush) begin
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
        end else if (slot_free) begin
          if (skid_valid) begin
            out_data   <= skid_data;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
          end else if (in_acc) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end else if (in_acc) begin
          skid_data  <= in_data;
          skid_valid <= 1'b1;
        end
      end
    end else begin : g_noskid
      logic out_acc;

      assign out_acc  = out_valid && out_ready;
      assign in_ready = slot_free;

      // single slot: load on accept, empty on drain without refill
      always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end else if (flush) begin
          out_valid <= 1'b0;
        end else if (in_acc) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else if (out_acc) begin
          out_valid <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/idexe_stage_reg.sv
// ID/EXE pipeline register: handshake stage, flush bubbles, saturating stall counter.
module idexe_stage_reg
  import idexe_stage_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int ALUC_W = ALUC_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
)(
  input  logic              clk,
  input  logic              clrn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              wreg,
  input  logic              m2reg,
  input  logic              wmem,
  input  logic              aluimm,
  input  logic [ALUC_W-1:0] aluc,
  input  logic [REG_AW-1:0] destReg,
  input  logic [DATA_W-1:0] qa,
  input  logic [DATA_W-1:0] qb,
  input  logic [DATA_W-1:0] imm32,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic              ealuimm,
  output logic [ALUC_W-1:0] ealuc,
  output logic [REG_AW-1:0] edestReg,
  output logic [DATA_W-1:0] eqa,
  output logic [DATA_W-1:0] eqb,
  output logic [DATA_W-1:0] eimm32,
  output logic [CNT_W-1:0]  stall_cnt
);

  // same layout as idexe_bundle_t, resized to this instance's widths
  typedef struct packed {
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic              aluimm;
    logic [ALUC_W-1:0] aluc;
    logic [REG_AW-1:0] dest_reg;
    logic [DATA_W-1:0] qa;
    logic [DATA_W-1:0] qb;
    logic [DATA_W-1:0] imm32;
  } bundle_t;

  localparam int              BW      = bundle_w(DATA_W, REG_AW, ALUC_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  bundle_t in_b, out_b;
  logic    vld;

  assign in_b = {wreg, m2reg, wmem, aluimm, aluc, destReg, qa, qb, imm32};

  pipe_skid_buf #(.W(BW), .SKID(SKID)) u_buf (
    .clk       (clk),
    .clrn      (clrn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_b),
    .out_valid (vld),
    .out_ready (out_ready),
    .out_data  (out_b)
  );

  // Side-effect bits are gated by valid: a bubble (drain or flush) can never
  // write the register file or memory, while the operand fields just hold.
  assign out_valid = vld;
  assign ewreg     = out_b.wreg  & vld;
  assign em2reg    = out_b.m2reg & vld;
  assign ewmem     = out_b.wmem  & vld;
  assign ealuimm   = out_b.aluimm;
  assign ealuc     = out_b.aluc;
  assign edestReg  = out_b.dest_reg;
  assign eqa       = out_b.qa;
  assign eqb       = out_b.qb;
  assign eimm32    = out_b.imm32;

  // count edges where EXE refuses a valid instruction; saturates, reset-only clear
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      stall_cnt <= '0;
    else if (vld && !out_ready && !flush && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_idexe_stage_reg.sv
// Bench: SKID=1 (CNT_W=4) and SKID=0 (CNT_W=16) instances share stimulus;
// each is compared against a queue-based occupancy model.
module tb_idexe_stage_reg;
  import idexe_stage_reg_pkg::*;

  logic        clk = 1'b0;
  logic        clrn, flush, in_valid, out_ready;
  logic        wreg, m2reg, wmem, aluimm;
  logic [3:0]  aluc;
  logic [4:0]  dest;
  logic [31:0] qa, qb, imm32;

  logic        s1_in_ready, s1_out_valid, s1_ewreg, s1_em2reg, s1_ewmem, s1_ealuimm;
  logic [3:0]  s1_ealuc;
  logic [4:0]  s1_edest;
  logic [31:0] s1_eqa, s1_eqb, s1_eimm;
  logic [3:0]  s1_stall_cnt;
  logic        s0_in_ready, s0_out_valid, s0_ewreg, s0_em2reg, s0_ewmem, s0_ealuimm;
  logic [3:0]  s0_ealuc;
  logic [4:0]  s0_edest;
  logic [31:0] s0_eqa, s0_eqb, s0_eimm;
  logic [15:0] s0_stall_cnt;

  idexe_bundle_t s1_b, s0_b;
  assign s1_b = {s1_ewreg, s1_em2reg, s1_ewmem, s1_ealuimm, s1_ealuc, s1_edest, s1_eqa, s1_eqb, s1_eimm};
  assign s0_b = {s0_ewreg, s0_em2reg, s0_ewmem, s0_ealuimm, s0_ealuc, s0_edest, s0_eqa, s0_eqb, s0_eimm};

  idexe_stage_reg #(.SKID(1), .CNT_W(4)) u_s1 (
    .clk(clk), .clrn(clrn), .flush(flush), .in_valid(in_valid), .in_ready(s1_in_ready),
    .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluimm(aluimm), .aluc(aluc), .destReg(dest),
    .qa(qa), .qb(qb), .imm32(imm32), .out_valid(s1_out_valid), .out_ready(out_ready),
    .ewreg(s1_ewreg), .em2reg(s1_em2reg), .ewmem(s1_ewmem), .ealuimm(s1_ealuimm),
    .ealuc(s1_ealuc), .edestReg(s1_edest), .eqa(s1_eqa), .eqb(s1_eqb), .eimm32(s1_eimm),
    .stall_cnt(s1_stall_cnt));

  idexe_stage_reg #(.SKID(0), .CNT_W(16)) u_s0 (
    .clk(clk), .clrn(clrn), .flush(flush), .in_valid(in_valid), .in_ready(s0_in_ready),
    .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluimm(aluimm), .aluc(aluc), .destReg(dest),
    .qa(qa), .qb(qb), .imm32(imm32), .out_valid(s0_out_valid), .out_ready(out_ready),
    .ewreg(s0_ewreg), .em2reg(s0_em2reg), .ewmem(s0_ewmem), .ealuimm(s0_ealuimm),
    .ealuc(s0_ealuc), .edestReg(s0_edest), .eqa(s0_eqa), .eqb(s0_eqb), .eimm32(s0_eimm),
    .stall_cnt(s0_stall_cnt));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // model: instructions held in the stage, oldest first; last shown fields
  idexe_bundle_t q1[$], q0[$];
  idexe_bundle_t sh1, sh0;
  int            cnt1, cnt0;

  function automatic idexe_bundle_t expect_of(idexe_bundle_t shown, bit v);
    idexe_bundle_t e;
    e = shown;
    if (!v) begin
      e.wreg  = 1'b0;
      e.m2reg = 1'b0;
      e.wmem  = 1'b0;
    end
    return e;
  endfunction

  task automatic model_reset();
    q1.delete(); q0.delete();
    sh1 = '0; sh0 = '0;
    cnt1 = 0; cnt0 = 0;
  endtask

  task automatic set_in(input logic v, input logic [31:0] a, input logic w);
    in_valid = v;
    qa = a; qb = ~a; imm32 = a ^ 32'h5a5a_5a5a;
    wreg = w; m2reg = w; wmem = w;
    aluimm = a[0]; aluc = a[3:0]; dest = a[8:4];
  endtask

  // one clock edge; model updated from the stage occupancy rules, ends 1ns after edge
  task automatic tick();
    idexe_bundle_t cur;
    bit a1, a0, d1, d0;
    cur = {wreg, m2reg, wmem, aluimm, aluc, dest, qa, qb, imm32};
    a1 = in_valid && (q1.size() < 2);
    a0 = in_valid && (q0.size() == 0 || out_ready);
    d1 = (q1.size() > 0) && out_ready;
    d0 = (q0.size() > 0) && out_ready;
    if (!flush) begin
      if (q1.size() > 0 && !out_ready && cnt1 < 15)    cnt1++;
      if (q0.size() > 0 && !out_ready && cnt0 < 65535) cnt0++;
    end
    @(posedge clk);
    if (flush) begin
      q1.delete(); q0.delete();
    end else begin
      if (d1) void'(q1.pop_front());
      if (a1) q1.push_back(cur);
      if (d0) void'(q0.pop_front());
      if (a0) q0.push_back(cur);
    end
    if (q1.size() > 0) sh1 = q1[0];
    if (q0.size() > 0) sh0 = q0[0];
    #1;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    set_in(1'b1, 32'h0bad_f00d, 1'b1);
    tick();
    checks++;
    if (s1_ewreg !== 1'b1 || s1_out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_load: got v=%b wreg=%b want 1 1", s1_out_valid, s1_ewreg);
    end
    set_in(1'b0, 32'h0, 1'b0);
    #1 clrn = 1'b0;
    #1;
    checks++;
    if ({s1_out_valid, s1_b} !== '0) begin
      errors++; $display("FAIL reset_s1_outputs: got %h want 0", {s1_out_valid, s1_b});
    end
    checks++;
    if ({s0_out_valid, s0_b} !== '0) begin
      errors++; $display("FAIL reset_s0_outputs: got %h want 0", {s0_out_valid, s0_b});
    end
    checks++;
    if (s1_in_ready !== 1'b1 || s0_in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b%b want 11", s1_in_ready, s0_in_ready);
    end
    checks++;
    if (s1_stall_cnt !== 4'd0 || s0_stall_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stall_cnt: got %0d/%0d want 0", s1_stall_cnt, s0_stall_cnt);
    end
    model_reset();
    @(negedge clk);
    clrn = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals = '{32'h11, 32'h22, 32'h33};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, vals[i], 1'b1);
      tick();
      checks++;
      if (s1_eqa !== vals[i] || s0_eqa !== vals[i] || s1_out_valid !== 1'b1) begin
        errors++; $display("FAIL stream_eqa[%0d]: got %h/%h want %h", i, s1_eqa, s0_eqa, vals[i]);
      end
      checks++;
      if (s1_in_ready !== 1'b1 || s1_stall_cnt !== 4'd0) begin
        errors++; $display("FAIL stream_ready_cnt[%0d]: got rdy=%b cnt=%0d want 1 0", i, s1_in_ready, s1_stall_cnt);
      end
    end
    set_in(1'b0, 32'h0, 1'b0);
    tick();
    checks++;
    if (s1_out_valid !== 1'b0 || s1_ewreg !== 1'b0 || s1_ewmem !== 1'b0 || s1_eqa !== 32'h33) begin
      errors++; $display("FAIL drain_bubble: got v=%b wreg=%b wmem=%b eqa=%h want 0 0 0 33",
                         s1_out_valid, s1_ewreg, s1_ewmem, s1_eqa);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    set_in(1'b1, 32'haaaa_0001, 1'b1);
    tick();
    out_ready = 1'b0;
    set_in(1'b1, 32'hbbbb_0002, 1'b0);
    tick();
    checks++;
    if (s1_in_ready !== 1'b0 || s1_eqa !== 32'haaaa_0001) begin
      errors++; $display("FAIL bp_skid_full: got rdy=%b eqa=%h want 0 aaaa0001", s1_in_ready, s1_eqa);
    end
    set_in(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    checks++;
    if (s1_stall_cnt !== 4'd3 || s1_eqa !== 32'haaaa_0001 || s1_out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got cnt=%0d eqa=%h v=%b want 3 aaaa0001 1", s1_stall_cnt, s1_eqa, s1_out_valid);
    end
    checks++;
    if (s0_stall_cnt !== 16'(cnt0)) begin
      errors++; $display("FAIL bp_s0_cnt: got %0d want %0d", s0_stall_cnt, cnt0);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (s1_eqa !== 32'hbbbb_0002 || s1_out_valid !== 1'b1 || s1_in_ready !== 1'b1 || s1_ewreg !== 1'b0) begin
      errors++; $display("FAIL bp_release: got eqa=%h v=%b rdy=%b wreg=%b want bbbb0002 1 1 0",
                         s1_eqa, s1_out_valid, s1_in_ready, s1_ewreg);
    end
    tick();
    checks++;
    if (s1_out_valid !== 1'b0 || s0_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drained: got %b/%b want 0", s1_out_valid, s0_out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    set_in(1'b1, 32'hf1a0_0005, 1'b1);
    tick();
    out_ready = 1'b0;
    set_in(1'b1, 32'hf1b0_0006, 1'b0);
    tick();
    set_in(1'b1, 32'hf1c0_0007, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    set_in(1'b0, 32'h0, 1'b0);
    checks++;
    if (s1_out_valid !== 1'b0 || s1_ewreg !== 1'b0 || s1_em2reg !== 1'b0 || s1_ewmem !== 1'b0) begin
      errors++; $display("FAIL flush_bubble: got v=%b ctl=%b%b%b want 0 000", s1_out_valid, s1_ewreg, s1_em2reg, s1_ewmem);
    end
    checks++;
    if (s1_eqa !== 32'hf1a0_0005 || s1_ealuc !== 4'h5 || s1_edest !== 5'h00 || s0_eqa !== 32'hf1a0_0005) begin
      errors++; $display("FAIL flush_hold: got eqa=%h aluc=%h s0eqa=%h want f1a00005 5 f1a00005", s1_eqa, s1_ealuc, s0_eqa);
    end
    checks++;
    if (s1_in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_ready: got %b want 1", s1_in_ready);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (s1_out_valid !== 1'b0 || s0_out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_dropped: got %b/%b want 0", s1_out_valid, s0_out_valid);
    end
  endtask

  task automatic test_skid0();
    out_ready = 1'b1;
    set_in(1'b1, 32'hd000_0008, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 1'b0);
    out_ready = 1'b0;
    #1;
    checks++;
    if (s0_in_ready !== 1'b0) begin
      errors++; $display("FAIL s0_stall_ready: got %b want 0", s0_in_ready);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (s0_in_ready !== 1'b1) begin
      errors++; $display("FAIL s0_release_ready: got %b want 1", s0_in_ready);
    end
    set_in(1'b1, 32'he000_0009, 1'b0);
    tick();
    checks++;
    if (s0_eqa !== 32'he000_0009 || s0_out_valid !== 1'b1) begin
      errors++; $display("FAIL s0_reload: got eqa=%h v=%b want e0000009 1", s0_eqa, s0_out_valid);
    end
    set_in(1'b0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_saturate();
    out_ready = 1'b1;
    set_in(1'b1, 32'h5a70_000a, 1'b1);
    tick();
    set_in(1'b0, 32'h0, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (s1_stall_cnt !== 4'(cnt1)) begin
        errors++; $display("FAIL sat_step[%0d]: got %0d want %0d", i, s1_stall_cnt, cnt1);
      end
    end
    checks++;
    if (s1_stall_cnt !== 4'hf) begin
      errors++; $display("FAIL sat_final: got %0d want 15", s1_stall_cnt);
    end
    checks++;
    if (s0_stall_cnt !== 16'(cnt0)) begin
      errors++; $display("FAIL sat_s0_cnt: got %0d want %0d", s0_stall_cnt, cnt0);
    end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    bit v1, v0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 20) == 0;
      {wreg, m2reg, wmem, aluimm, aluc, dest} = 13'($urandom);
      qa = $urandom; qb = $urandom; imm32 = $urandom;
      #1;
      checks++;
      if (s1_in_ready !== (q1.size() < 2) || s0_in_ready !== (q0.size() == 0 || out_ready)) begin
        errors++; $display("FAIL rnd_ready[%0d]: got %b%b want %b%b", i, s1_in_ready, s0_in_ready,
                           q1.size() < 2, q0.size() == 0 || out_ready);
      end
      tick();
      v1 = q1.size() > 0;
      v0 = q0.size() > 0;
      checks++;
      if ({s1_out_valid, s1_b} !== {v1, expect_of(sh1, v1)}) begin
        errors++; $display("FAIL rnd_s1_out[%0d]: got %h want %h", i, {s1_out_valid, s1_b}, {v1, expect_of(sh1, v1)});
      end
      checks++;
      if ({s0_out_valid, s0_b} !== {v0, expect_of(sh0, v0)}) begin
        errors++; $display("FAIL rnd_s0_out[%0d]: got %h want %h", i, {s0_out_valid, s0_b}, {v0, expect_of(sh0, v0)});
      end
      checks++;
      if (s1_stall_cnt !== 4'(cnt1) || s0_stall_cnt !== 16'(cnt0)) begin
        errors++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, s1_stall_cnt, s0_stall_cnt, cnt1, cnt0);
      end
    end
    flush = 1'b0;
  endtask

  initial begin
    clrn = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b0, 32'h0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_skid0();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idexe_stage_reg.md
Name: idexe_stage_reg

Overview:
Parametrised ID/EXE pipeline register for the next-generation pipeline. It replaces the free-running stage latch with three additions:
- valid/ready handshake with an optional one-entry skid buffer, so stalls propagate without combinational ready paths;
- synchronous flush that inserts a bubble;
- async active-low reset and a saturating stall counter.

It sits between decode (register-file read, immediate extend, control unit) and the ALU stage.

Parameters:
DATA_W, 32, width of qa, qb, imm32 operands
REG_AW, 5, destination register index width
ALUC_W, 4, ALU control code width
SKID, 1, 1 = one-entry skid buffer with registered in_ready; 0 = no skid, in_ready combinational
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of all held and incoming instructions
in_valid  in  1  decode presents a valid instruction
in_ready  out  1  stage can accept this cycle
wreg, m2reg, wmem, aluimm  in  1 each  decode control bits
aluc  in  ALUC_W  ALU op
destReg  in  REG_AW  destination register
qa, qb, imm32  in  DATA_W each  operands
out_valid  out  1  e* fields hold a valid instruction
out_ready  in  1  EXE consumes this cycle
ewreg, em2reg, ewmem, ealuimm  out  1 each  registered control
ealuc  out  ALUC_W
edestReg  out  REG_AW
eqa, eqb, eimm32  out  DATA_W each
stall_cnt  out  CNT_W  count of stalled cycles

Behaviour:
- Clock and reset: one clock, clk; reset clrn is asynchronous and active-low.
- Reset (clrn=0): immediately clears all e* outputs to 0, out_valid=0, skid entry invalid and zeroed, stall_cnt=0. in_ready=1 during and after reset.
- Accept: in_acc = in_valid && in_ready. Drain: out_acc = out_valid && out_ready.
- Latency: 1 cycle from in_acc to out_valid when the output slot is empty or draining.
- SKID=1, in_ready = !skid_valid (register output only).
  - Slot empty or draining (out_acc or !out_valid):
    - Skid valid: the output loads from skid and skid_valid clears.
    - Else, if in_acc: the output loads from the inputs.
    - out_valid = 1 only if a load happened.
  - Output full and !out_ready: if in_acc, inputs are captured into skid and skid_valid=1; the output holds.
  - Order is preserved: skid contents always precede newer input.
- SKID=0: in_ready = !out_valid || out_ready (combinational). The output loads on in_acc, clears out_valid on out_acc without in_acc, and otherwise holds.
- Flush (flush=1 at an edge, highest priority after reset):
  - out_valid=0, skid_valid=0.
  - ewreg, em2reg, ewmem cleared to 0 (bubble can never write the register file or memory).
  - The same-cycle input is dropped even if in_acc.
  - Data outputs and ealuc/ealuimm/edestReg hold their previous values.
  - in_ready is 1 in the following cycle.
- Bubble rule: whenever out_valid falls to 0 (drain without refill, or flush), ewreg/em2reg/ewmem become 0 at that edge.
- stall_cnt: +1 on each edge where out_valid && !out_ready && !flush. It saturates at 2^CNT_W-1 (no wrap) and is cleared only by reset.
- Unknown inputs while in_valid=0 must not alter any output.

Decomposition:
- Shared pipeline package: ALUC_W, REG_AW, and DATA_W defaults; ALU-op constants; an ID/EXE bundle typedef (control bits plus operand fields) used for both the output register and the skid entry.
- One sub-module is natural: pipe_skid_buf, a generic one-entry valid/ready skid buffer on a packed vector. idexe_stage_reg instantiates it, adds the flush/bubble gating and stall counter, and unpacks the fields.

Test Plan:
- Reset mid-stream: assert clrn=0 while out_valid=1 with ewreg=1 -> all outputs 0 immediately (before the next edge); in_ready=1; stall_cnt=0.
- Streaming, out_ready=1, qa=32'h11,22,33 on consecutive cycles -> eqa shows 11,22,33 one cycle later each; in_ready stays 1; stall_cnt=0.
- Backpressure, SKID=1: out holds A, out_ready=0, present B -> B goes to skid and in_ready=0. Hold 3 cycles -> stall_cnt=3, eqa=A. Release -> A consumed, then B appears next cycle with order kept, then in_ready=1.
- Flush with full skid: out=A with wreg=1, skid=B, in_valid=1 with C, flush=1 -> out_valid=0, ewreg=ewmem=em2reg=0, eqa still A, C never appears, in_ready=1 next cycle.
- SKID=0 stall: out_valid=1, out_ready=0 -> in_ready=0 in the same cycle. Set out_ready=1 -> in_ready=1 combinationally and new data is loaded at the edge.
- Saturation with CNT_W=4: 20 stalled cycles -> stall_cnt=15, holding, no wrap.
